// File: rtl/writeback_stage.sv
// Writeback stage: stage register, 32x32 register file with combinational reads,
// and a retired-instruction counter. Optional read bypass via WRITEBACK_BYPASS_EN.
module writeback_stage #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [1:0]         bundle_in,
  input  logic [4:0]         write_reg_in,
  input  logic [31:0]        pc_seq_in,
  input  logic [31:0]        data_in,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [4:0]         rs_addr_in,
  input  logic [4:0]         rt_addr_in,
  output logic [31:0]        rs_data_out,
  output logic [31:0]        rt_data_out,
  output logic               wb_valid_out,
  output logic [4:0]         wb_reg_out,
  output logic [31:0]        wb_data_out,
  output logic [COUNT_W-1:0] retired_count_out
);

  logic        s_valid;
  logic        s_regwrite;
  logic        s_link;
  logic [4:0]  s_wreg;
  logic [31:0] s_pc_seq;
  logic [31:0] s_data;
  logic        s_committed;

  logic        commit;
  logic [31:0] commit_data;
  logic [31:0] rf [32];

  assign commit       = s_valid & ~s_committed;
  assign commit_data  = s_link ? s_pc_seq : s_data;
  assign wb_valid_out = commit & s_regwrite & (s_wreg != 5'd0);
  assign wb_reg_out   = s_wreg;
  assign wb_data_out  = commit_data;

  // A stalled instruction stays in S but is marked committed after its first edge,
  // so it retires exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid     <= 1'b0;
      s_regwrite  <= 1'b0;
      s_link      <= 1'b0;
      s_wreg      <= '0;
      s_pc_seq    <= '0;
      s_data      <= '0;
      s_committed <= 1'b0;
    end else if (flush_in) begin
      s_valid     <= 1'b0;
      s_regwrite  <= 1'b0;
      s_link      <= 1'b0;
      s_wreg      <= '0;
      s_pc_seq    <= '0;
      s_data      <= '0;
      s_committed <= 1'b0;
    end else if (stall_in) begin
      s_committed <= s_committed | commit;
    end else begin
      s_valid     <= valid_in;
      s_regwrite  <= bundle_in[0];
      s_link      <= bundle_in[1];
      s_wreg      <= write_reg_in;
      s_pc_seq    <= pc_seq_in;
      s_data      <= data_in;
      s_committed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid_out) begin
      rf[s_wreg] <= commit_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_count_out <= '0;
    else if (commit) retired_count_out <= retired_count_out + 1'b1;
  end

  always_comb begin
    rs_data_out = (rs_addr_in == 5'd0) ? '0 : rf[rs_addr_in];
    rt_data_out = (rt_addr_in == 5'd0) ? '0 : rf[rt_addr_in];
`ifdef WRITEBACK_BYPASS_EN
    if (wb_valid_out && (rs_addr_in == wb_reg_out)) rs_data_out = wb_data_out;
    if (wb_valid_out && (rt_addr_in == wb_reg_out)) rt_data_out = wb_data_out;
`endif
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected commits are queued at issue and
// compared against the forwarding outputs while the instruction sits in the stage.
module tb_writeback_stage;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [1:0]    bundle_in;
  logic [4:0]    write_reg_in;
  logic [31:0]   pc_seq_in;
  logic [31:0]   data_in;
  logic          stall_in;
  logic          flush_in;
  logic [4:0]    rs_addr_in;
  logic [4:0]    rt_addr_in;
  logic [31:0]   rs_data_out;
  logic [31:0]   rt_data_out;
  logic          wb_valid_out;
  logic [4:0]    wb_reg_out;
  logic [31:0]   wb_data_out;
  logic [CW-1:0] retired_count_out;

  writeback_stage #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .bundle_in(bundle_in),
    .write_reg_in(write_reg_in), .pc_seq_in(pc_seq_in), .data_in(data_in),
    .stall_in(stall_in), .flush_in(flush_in), .rs_addr_in(rs_addr_in),
    .rt_addr_in(rt_addr_in), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
    .wb_valid_out(wb_valid_out), .wb_reg_out(wb_reg_out), .wb_data_out(wb_data_out),
    .retired_count_out(retired_count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   model_rf [32];
  logic [CW-1:0] model_cnt;
  int            tests = 0;
  int            fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    model_cnt = '0;
    sb.delete();
  endtask

  // Drive one instruction, queue its expected commit, capture it, then present a bubble.
  task automatic load(input logic [1:0] b, input logic [4:0] r,
                      input logic [31:0] pc, input logic [31:0] d);
    exp_t e;
    valid_in = 1'b1; bundle_in = b; write_reg_in = r; pc_seq_in = pc; data_in = d;
    e.v = b[0] && (r != 5'd0);
    e.r = r;
    e.d = b[1] ? pc : d;
    sb.push_back(e);
    if (e.v) model_rf[r] = e.d;
    model_cnt = model_cnt + 1'b1;
    step();
    valid_in = 1'b0; bundle_in = '0; write_reg_in = '0; pc_seq_in = '0; data_in = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; valid_in = 1'b0; bundle_in = '0; write_reg_in = '0; pc_seq_in = '0;
    data_in = '0; stall_in = 1'b0; flush_in = 1'b0; rs_addr_in = 5'd5; rt_addr_in = 5'd31;
    model_clear();
    step(); step();
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out, rs_data_out, rt_data_out, retired_count_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b r=%0d d=%h rs=%h rt=%h cnt=%0d, want all 0",
               wb_valid_out, wb_reg_out, wb_data_out, rs_data_out, rt_data_out, retired_count_out);
    end
    reset = 1'b0;
    step();
    tests++;
    if (retired_count_out !== '0) begin
      fails++;
      $display("FAIL reset_idle_count: got %0d, want 0", retired_count_out);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    load(2'b01, 5'd5, 32'h0, 32'h1234ABCD);
    e = sb.pop_front();
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd5, 32'h1234ABCD}) begin
      fails++;
      $display("FAIL basic_wb: got v=%b r=%0d d=%h, want v=%b r=%0d d=%h",
               wb_valid_out, wb_reg_out, wb_data_out, e.v, e.r, e.d);
    end
    step();
    rs_addr_in = 5'd5; #1;
    tests++;
    if (rs_data_out !== 32'h1234ABCD || retired_count_out !== 8'd1) begin
      fails++;
      $display("FAIL basic_commit: got reg5=%h cnt=%0d, want 1234abcd cnt=1", rs_data_out, retired_count_out);
    end
  endtask

  task automatic test_link();
    exp_t e;
    load(2'b11, 5'd31, 32'h00400008, 32'hDEADBEEF);
    e = sb.pop_front();
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {e.v, e.r, e.d}) begin
      fails++;
      $display("FAIL link_wb: got v=%b r=%0d d=%h, want v=%b r=%0d d=%h",
               wb_valid_out, wb_reg_out, wb_data_out, e.v, e.r, e.d);
    end
    load(2'b01, 5'd0, 32'h0, 32'hCAFEF00D);
    e = sb.pop_front();
    tests++;
    if (wb_valid_out !== 1'b0 || wb_data_out !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL reg0_wb: got v=%b d=%h, want v=0 d=cafef00d", wb_valid_out, wb_data_out);
    end
    step();
    rs_addr_in = 5'd31; rt_addr_in = 5'd0; #1;
    tests++;
    if (rs_data_out !== 32'h00400008 || rt_data_out !== 32'h0 || retired_count_out !== 8'd3) begin
      fails++;
      $display("FAIL link_commit: got reg31=%h reg0=%h cnt=%0d, want 00400008 0 3",
               rs_data_out, rt_data_out, retired_count_out);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    load(2'b01, 5'd9, 32'h0, 32'h5A5A0009);
    e = sb.pop_front();
    stall_in = 1'b1;
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {e.v, e.r, e.d}) begin
      fails++;
      $display("FAIL stall_first_wb: got v=%b r=%0d d=%h, want v=%b r=%0d d=%h",
               wb_valid_out, wb_reg_out, wb_data_out, e.v, e.r, e.d);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (wb_valid_out !== 1'b0 || retired_count_out !== model_cnt) begin
        fails++;
        $display("FAIL stall_hold_%0d: got v=%b cnt=%0d, want v=0 cnt=%0d",
                 i, wb_valid_out, retired_count_out, model_cnt);
      end
      step();
    end
    stall_in = 1'b0;
    step();
    rs_addr_in = 5'd9; #1;
    tests++;
    if (rs_data_out !== 32'h5A5A0009 || retired_count_out !== model_cnt) begin
      fails++;
      $display("FAIL stall_once: got reg9=%h cnt=%0d, want 5a5a0009 cnt=%0d",
               rs_data_out, retired_count_out, model_cnt);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    load(2'b01, 5'd7, 32'h0, 32'h000000FF);
    e = sb.pop_front();
    flush_in = 1'b1;
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out} !== {e.v, e.r, e.d}) begin
      fails++;
      $display("FAIL flush_pending_wb: got v=%b r=%0d d=%h, want v=%b r=%0d d=%h",
               wb_valid_out, wb_reg_out, wb_data_out, e.v, e.r, e.d);
    end
    step();
    flush_in = 1'b0;
    rs_addr_in = 5'd7; #1;
    tests++;
    if (rs_data_out !== 32'hFF || wb_valid_out !== 1'b0 || retired_count_out !== model_cnt) begin
      fails++;
      $display("FAIL flush_commit: got reg7=%h v=%b cnt=%0d, want ff v=0 cnt=%0d",
               rs_data_out, wb_valid_out, retired_count_out, model_cnt);
    end
    step();
    tests++;
    if (retired_count_out !== model_cnt) begin
      fails++;
      $display("FAIL flush_bubble: got cnt=%0d, want %0d", retired_count_out, model_cnt);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] want;
    load(2'b01, 5'd3, 32'h0, 32'h00000011);
    e = sb.pop_front();
    step();
    want = model_rf[3];
    load(2'b01, 5'd3, 32'h0, 32'h000000AA);
    e = sb.pop_front();
    rs_addr_in = 5'd3; rt_addr_in = 5'd3; #1;
`ifdef WRITEBACK_BYPASS_EN
    want = 32'hAA;
`endif
    tests++;
    if (rs_data_out !== want || rt_data_out !== want || wb_data_out !== e.d) begin
      fails++;
      $display("FAIL bypass_pre_edge: got rs=%h rt=%h wbd=%h, want rs=rt=%h wbd=%h",
               rs_data_out, rt_data_out, wb_data_out, want, e.d);
    end
    step();
    tests++;
    if (rs_data_out !== 32'hAA) begin
      fails++;
      $display("FAIL bypass_post_edge: got %h, want aa", rs_data_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      load(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      e = sb.pop_front();
      tests++;
      if ({wb_valid_out, wb_reg_out, wb_data_out} !== {e.v, e.r, e.d}) begin
        fails++;
        $display("FAIL b2b_wb_%0d: got v=%b r=%0d d=%h, want v=%b r=%0d d=%h",
                 i, wb_valid_out, wb_reg_out, wb_data_out, e.v, e.r, e.d);
      end
    end
    step();
    for (int i = 0; i < 32; i++) begin
      rs_addr_in = 5'(i); rt_addr_in = 5'(31 - i); #1;
      tests++;
      if (rs_data_out !== model_rf[i] || rt_data_out !== model_rf[31 - i]) begin
        fails++;
        $display("FAIL b2b_reg_%0d: got rs=%h rt=%h, want rs=%h rt=%h",
                 i, rs_data_out, rt_data_out, model_rf[i], model_rf[31 - i]);
      end
    end
    tests++;
    if (retired_count_out !== model_cnt) begin
      fails++;
      $display("FAIL b2b_count: got %0d, want %0d", retired_count_out, model_cnt);
    end
  endtask

  task automatic test_wrap();
    while (model_cnt != '1) load(2'b00, 5'd0, 32'h0, 32'h0);
    sb.delete();
    step();
    tests++;
    if (retired_count_out !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_allones: got %0d, want 255", retired_count_out);
    end
    load(2'b00, 5'd4, 32'h0, 32'h1);
    sb.delete();
    step();
    tests++;
    if (retired_count_out !== 8'h00) begin
      fails++;
      $display("FAIL wrap_zero: got %0d, want 0", retired_count_out);
    end
  endtask

  task automatic test_reset_mid();
    load(2'b01, 5'd12, 32'h0, 32'h00C0FFEE);
    rs_addr_in = 5'd5; rt_addr_in = 5'd31;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({wb_valid_out, wb_reg_out, wb_data_out, rs_data_out, rt_data_out, retired_count_out} !== '0) begin
      fails++;
      $display("FAIL reset_async: got v=%b r=%0d d=%h rs=%h rt=%h cnt=%0d, want all 0",
               wb_valid_out, wb_reg_out, wb_data_out, rs_data_out, rt_data_out, retired_count_out);
    end
    step();
    reset = 1'b0;
    model_clear();
    rs_addr_in = 5'd12; #1;
    step();
    tests++;
    if (rs_data_out !== 32'h0 || retired_count_out !== '0) begin
      fails++;
      $display("FAIL reset_suppress: got reg12=%h cnt=%0d, want 0 0", rs_data_out, retired_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_link();
    test_stall();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter COUNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  memory stage presents a real instruction; 0 = bubble.
REQ-005 bundle_in  input  2  bit0 reg-write enable; bit1 link select (write pc_seq instead of data).
REQ-006 write_reg_in  input  5  destination register index.
REQ-007 pc_seq_in  input  32  sequential PC for link writes.
REQ-008 data_in  input  32  memory-stage result (ALU/RAM mux output).
REQ-009 stall_in  input  1  hold the stage register.
REQ-010 flush_in  input  1  replace the stage register with a bubble.
REQ-011 rs_addr_in, rt_addr_in  input  5 each  decode read addresses.
REQ-012 rs_data_out, rt_data_out  output  32 each  combinational register-file read data.
REQ-013 wb_valid_out  output  1  a register write commits at the next edge.
REQ-014 wb_reg_out  output  5  commit destination, for forwarding.
REQ-015 wb_data_out  output  32  commit data, for forwarding.
REQ-016 retired_count_out  output  COUNT_W  count of committed instructions.

Function
REQ-017 Stage register S SHALL hold: valid, regwrite, link, wreg, pc_seq, data and a committed flag.
REQ-018 Commit SHALL occur on an edge when S.valid=1 and S.committed=0.
REQ-019 Commit data SHALL be pc_seq when link=1, else data; wb_data_out SHALL always show this value.
REQ-020 On commit with regwrite=1 and wreg!=0, the block SHALL write regfile[wreg]; wreg=0 SHALL never be written.
REQ-021 Every commit SHALL increment retired_count_out by 1, regardless of regwrite; it SHALL wrap from all-ones to 0.
REQ-022 wb_valid_out SHALL be S.valid & ~S.committed & regwrite & (wreg!=0); wb_reg_out SHALL equal S.wreg.
REQ-023 S next-state priority: flush_in -> bubble (valid=0, committed=0); else stall_in -> hold all fields, committed <= committed | (commit this edge); else load inputs with committed=0.
REQ-024 A held instruction SHALL commit exactly once, however long the stall lasts.
REQ-025 Flush on the same edge as a commit: the commit SHALL still take effect, and S SHALL become a bubble.
REQ-026 Register 0 SHALL read as 0; reads of any other address SHALL be combinational from the array.
REQ-027 Latency: inputs captured at edge N commit at edge N+1 (no stall), and are visible on read ports after edge N+1.

Reset
REQ-028 While reset is high: S valid=0, committed=0, all fields 0; all 32 registers 0; retired_count_out=0.
REQ-029 Reset asserted mid-operation SHALL suppress any pending commit.
REQ-030 Reset outputs: wb_valid_out=0, wb_reg_out=0, wb_data_out=0, rs/rt_data_out=0.

Configuration
REQ-031 Macro WRITEBACK_BYPASS_EN defined: when wb_valid_out=1 and a read address equals wb_reg_out (nonzero), that read port SHALL return wb_data_out.
REQ-032 Macro WRITEBACK_BYPASS_EN undefined: read ports SHALL return the array contents only, and the new value becomes visible after the commit edge.

Verification
REQ-033 Load valid=1, bundle=01, wreg=5, data=0x1234ABCD; next edge -> reg5 reads 0x1234ABCD and retired_count_out=1.
REQ-034 Load bundle=11, wreg=31, pc_seq=0x00400008 -> reg31=0x00400008; with bundle=01 and wreg=0 -> reg0 stays 0 and the count still increments.
REQ-035 Load an instruction, then hold stall_in=1 for 4 cycles -> exactly one write and a count increment of exactly 1; wb_valid_out=1 only in the first cycle.
REQ-036 Assert flush_in together with a pending commit (wreg=7, data=0xFF) -> reg7=0xFF, next S is a bubble, wb_valid_out=0.
REQ-037 Pending write reg3=0xAA with rs_addr_in=3 -> rs_data_out=0xAA before the edge when WRITEBACK_BYPASS_EN is defined, and the old value when it is not.
REQ-038 Preset the counter to all-ones and commit once -> count=0; assert reset mid-stream -> all registers and outputs become 0 immediately, without waiting for clk.
